// File: rtl/serial_bcs_compare.sv
// rtl/serial_bcs_compare.sv - bit-serial MSB-first magnitude comparator with start/busy/done handshake (optional EARLY_EXIT_EN)
module serial_bcs_compare #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             g_q, g_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    // One bit-comparator stage fed by the current top bits of the operand shifters.
    logic ai, bi, e_step, g_step, last_step, exit_run;
    assign ai        = a_q[WIDTH-1];
    assign bi        = b_q[WIDTH-1];
    assign e_step    = e_q & ~(ai ^ bi);
    assign g_step    = g_q | (e_q & ai & ~bi);
    assign last_step = (cnt_q == CW'(1));
`ifdef EARLY_EXIT_EN
    // The first differing bit already decides the result, so stop there.
    assign exit_run  = last_step | ~e_step;
`else
    assign exit_run  = last_step;
`endif

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

    // Next-state logic: accept in IDLE/DONE, scan one bit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        g_d     = g_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    e_d     = 1'b1;
                    g_d     = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                e_d   = e_step;
                g_d   = g_step;
                a_d   = {a_q[WIDTH-2:0], 1'b0};
                b_d   = {b_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (exit_run) begin
                    eq_d    = e_step;
                    gt_d    = g_step;
                    lt_d    = ~e_step & ~g_step;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand shifters, scan flags and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            e_q     <= 1'b1;
            g_q     <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            g_q     <= g_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

endmodule

// File: tb/tb_serial_bcs_compare.sv
// tb/tb_serial_bcs_compare.sv - directed self-checking bench for serial_bcs_compare (WIDTH=8)
module tb_serial_bcs_compare;

    localparam int W = 8;

`ifdef EARLY_EXIT_EN
    localparam int L_80 = 2;
    localparam int L_01 = 8;
    localparam int L_03 = 8;
    localparam int L_10 = 4;
`else
    localparam int L_80 = 9;
    localparam int L_01 = 9;
    localparam int L_03 = 9;
    localparam int L_10 = 9;
`endif
    localparam int L_EQ = 9;
    localparam int L_0E = 9;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;

    int n_checks;
    int n_fail;

    serial_bcs_compare #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called on the first negedge after the accepting edge (cycle 1); returns on the done cycle.
    task automatic wait_done(output int lat, output int nb);
        lat = 1;
        nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_cmp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2:0] exp_res, input int exp_lat);
        int lat, nb;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = ~bv;
        wait_done(lat, nb);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, nb, exp_lat - 1);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_res"}, {eq, gt, lt}, exp_res);
        @(negedge clk);
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
        check({tag, "_res_hold"}, {eq, gt, lt}, exp_res);
    endtask

    initial begin
        int lat, nb, nd;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {eq, gt, lt}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_cmp("eq5a", 8'h5A, 8'h5A, 3'b100, L_EQ);
        run_cmp("msb", 8'h80, 8'h7F, 3'b010, L_80);
        run_cmp("late", 8'h01, 8'h02, 3'b001, L_01);
        run_cmp("max", 8'hFF, 8'hFE, 3'b010, L_80 == 2 ? 9 : 9);

        // start during RUN is ignored; exactly one done pulse
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                nd++;
                lat = i;
            end
            if (i == 3) begin
                a = 8'hFF; b = 8'h00; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            @(negedge clk);
        end
        check("busy_start_dones", nd, 1);
        check("busy_start_lat", lat, L_10);
        check("busy_start_res", {eq, gt, lt}, 3'b001);

        // asynchronous reset in the 4th busy cycle
        @(negedge clk);
        a = 8'hC3; b = 8'hC3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_res", {eq, gt, lt}, 3'b000);
        @(negedge clk);
        check("rst_mid_hold", {busy, done, eq, gt, lt}, 5'b0);
        rst_n = 1'b1;
        run_cmp("after_rst", 8'h03, 8'h01, 3'b010, L_03);

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h0F; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        wait_done(lat, nb);
        check("b2b1_lat", lat, L_EQ);
        check("b2b1_res", {eq, gt, lt}, 3'b100);
        a = 8'h0E; b = 8'h0F;
        @(negedge clk);
        check("b2b_restart", {busy, done}, 2'b10);
        check("b2b_res_hold", {eq, gt, lt}, 3'b100);
        start = 1'b0;
        wait_done(lat, nb);
        check("b2b2_lat", lat, L_0E);
        check("b2b2_busy_cycles", nb, L_0E - 1);
        check("b2b2_res", {eq, gt, lt}, 3'b001);
        @(negedge clk);
        check("b2b2_idle", {busy, done}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
